// File: rtl/uart_frame_parser.sv
// Variable-length UART frame parser: HEADER|LEN|CMD|PAYLOAD[N]|CHK|TAIL, payload streamed out on valid/ready.
// Optional inter-byte timeout enabled by defining FRAME_PARSER_TIMEOUT_EN.
module uart_frame_parser #(
  parameter logic [7:0] HEADER_BYTE    = 8'h52,
  parameter logic [7:0] TAIL_BYTE      = 8'h9A,
  parameter logic [7:0] CMD_BYTE       = 8'h01,
  parameter int         LEN_OFFSET     = 6,
  parameter int         MAX_PAYLOAD    = 8,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err_fmt,
  output logic        err_chk,
  output logic        err_ovf,
  output logic        err_timeout,
  output logic [15:0] frame_cnt
);

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  typedef enum logic [2:0] {
    S_HUNT, S_LEN, S_CMD, S_DATA, S_CHK, S_TAIL, S_EMIT
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  sum_reg, sum_next;
  logic [7:0]  len_reg, len_next;
  logic [7:0]  idx_reg, idx_next;
  logic [7:0]  out_data_reg;
  logic        out_last_reg;
  logic        done_reg, done_next;
  logic        err_fmt_reg, err_fmt_next;
  logic        err_chk_reg, err_chk_next;
  logic        err_ovf_reg, err_ovf_next;
  logic        err_timeout_reg, err_timeout_next;
  logic [15:0] frame_cnt_reg;
  logic        cnt_inc;
  logic        mem_we;
  logic        byte_acc;
  logic        in_frame;
  logic        tmo_hit;
  logic [8:0]  n_calc;
  logic [7:0]  mem [MAX_PAYLOAD];

  assign byte_acc = in_valid && en;
  assign in_frame = (state_reg == S_LEN) || (state_reg == S_CMD) || (state_reg == S_DATA) ||
                    (state_reg == S_CHK) || (state_reg == S_TAIL);
  // 9-bit so that LEN < LEN_OFFSET wraps high and fails the range check
  assign n_calc   = {1'b0, in_data} - 9'(LEN_OFFSET);

`ifdef FRAME_PARSER_TIMEOUT_EN
  logic [15:0] idle_cnt_reg;

  assign tmo_hit = in_frame && !byte_acc && (idle_cnt_reg == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_reg <= '0;
    end else if (!en || !in_frame || byte_acc) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 16'd1;
    end
  end
`else
  // keeps the timeout parameter referenced in builds without the counter
  logic [15:0] tmo_unused;
  assign tmo_unused = 16'(TIMEOUT_CYCLES);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    sum_next         = sum_reg;
    len_next         = len_reg;
    idx_next         = idx_reg;
    done_next        = 1'b0;
    err_fmt_next     = 1'b0;
    err_chk_next     = 1'b0;
    err_ovf_next     = 1'b0;
    err_timeout_next = 1'b0;
    cnt_inc          = 1'b0;
    mem_we           = 1'b0;
    if (!en) begin
      state_next = S_HUNT;
    end else if (tmo_hit) begin
      err_timeout_next = 1'b1;
      state_next       = S_HUNT;
    end else begin
      case (state_reg)
        S_HUNT: begin
          if (byte_acc && (in_data == HEADER_BYTE)) begin
            sum_next   = in_data;
            state_next = S_LEN;
          end
        end
        S_LEN: begin
          if (byte_acc) begin
            sum_next = sum_reg + in_data;
            if ((n_calc != 9'd0) && (n_calc <= 9'(MAX_PAYLOAD))) begin
              len_next   = n_calc[7:0];
              state_next = S_CMD;
            end else begin
              err_fmt_next = 1'b1;
              state_next   = S_HUNT;
            end
          end
        end
        S_CMD: begin
          if (byte_acc) begin
            sum_next = sum_reg + in_data;
            if (in_data == CMD_BYTE) begin
              idx_next   = 8'd0;
              state_next = S_DATA;
            end else begin
              err_fmt_next = 1'b1;
              state_next   = S_HUNT;
            end
          end
        end
        S_DATA: begin
          if (byte_acc) begin
            sum_next = sum_reg + in_data;
            mem_we   = 1'b1;
            if (idx_reg == len_reg - 8'd1) begin
              state_next = S_CHK;
            end else begin
              idx_next = idx_reg + 8'd1;
            end
          end
        end
        S_CHK: begin
          if (byte_acc) begin
            sum_next   = sum_reg + in_data;
            state_next = S_TAIL;
          end
        end
        S_TAIL: begin
          if (byte_acc) begin
            sum_next = sum_reg + in_data;
            // a bad tail is reported as a format error even when the sum is also wrong
            if (in_data != TAIL_BYTE) begin
              err_fmt_next = 1'b1;
              state_next   = S_HUNT;
            end else if (sum_reg != 8'd0) begin
              err_chk_next = 1'b1;
              state_next   = S_HUNT;
            end else begin
              idx_next   = 8'd0;
              state_next = S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (byte_acc) begin
            err_ovf_next = 1'b1;
          end
          if (out_ready) begin
            if (idx_reg == len_reg - 8'd1) begin
              done_next  = 1'b1;
              cnt_inc    = 1'b1;
              state_next = S_HUNT;
            end else begin
              idx_next = idx_reg + 8'd1;
            end
          end
        end
        default: state_next = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_reg[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_HUNT;
      sum_reg         <= '0;
      len_reg         <= '0;
      idx_reg         <= '0;
      out_data_reg    <= '0;
      out_last_reg    <= 1'b0;
      done_reg        <= 1'b0;
      err_fmt_reg     <= 1'b0;
      err_chk_reg     <= 1'b0;
      err_ovf_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      sum_reg         <= sum_next;
      len_reg         <= len_next;
      idx_reg         <= idx_next;
      done_reg        <= done_next;
      err_fmt_reg     <= err_fmt_next;
      err_chk_reg     <= err_chk_next;
      err_ovf_reg     <= err_ovf_next;
      err_timeout_reg <= err_timeout_next;
      // read address follows idx_next, so data holds while the consumer stalls
      if (state_next == S_EMIT) begin
        out_data_reg <= mem[idx_next[AW-1:0]];
      end
      out_last_reg <= (state_next == S_EMIT) && (idx_next == len_next - 8'd1);
      if (cnt_inc) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign out_valid   = (state_reg == S_EMIT);
  assign busy        = (state_reg != S_HUNT);
  assign out_data    = out_data_reg;
  assign out_last    = out_last_reg;
  assign done        = done_reg;
  assign err_fmt     = err_fmt_reg;
  assign err_chk     = err_chk_reg;
  assign err_ovf     = err_ovf_reg;
  assign err_timeout = err_timeout_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good, corrupt, aborted and back-pressured frames.
// With FRAME_PARSER_TIMEOUT_EN defined the stall test expects an err_timeout pulse.
module tb_uart_frame_parser;

  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err_fmt;
  logic        err_chk;
  logic        err_ovf;
  logic        err_timeout;
  logic [15:0] frame_cnt;

  uart_frame_parser dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err_fmt    (err_fmt),
    .err_chk    (err_chk),
    .err_ovf    (err_ovf),
    .err_timeout(err_timeout),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks_n = 0;
  int fails_n  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      fails_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor: counts pulses and captures handshaken payload on the falling edge
  int         done_n = 0, fmt_n = 0, chk_n = 0, ovf_n = 0, tmo_n = 0, ovalid_n = 0, hold_n = 0;
  int         cap_n = 0;
  logic [7:0] cap_d [256];
  logic       cap_l [256];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic       prev_l = 1'b0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (cap_n < 256) begin
        cap_d[cap_n] = out_data;
        cap_l[cap_n] = out_last;
      end
      cap_n++;
    end
    if (out_valid)   ovalid_n++;
    if (done)        done_n++;
    if (err_fmt)     fmt_n++;
    if (err_chk)     chk_n++;
    if (err_ovf)     ovf_n++;
    if (err_timeout) tmo_n++;
    if (prev_stall && (!out_valid || out_data !== prev_d || out_last !== prev_l)) hold_n++;
    prev_stall = out_valid && !out_ready;
    prev_d     = out_data;
    prev_l     = out_last;
  end

  int b_done, b_fmt, b_chk, b_ovf, b_tmo, b_ovalid, b_hold, b_cap;
  int exp_cnt;
  logic [7:0] exp_pl [8];
  logic [7:0] frm_q [$];

  task automatic snap();
    b_done = done_n; b_fmt = fmt_n; b_chk = chk_n; b_ovf = ovf_n;
    b_tmo = tmo_n; b_ovalid = ovalid_n; b_hold = hold_n; b_cap = cap_n;
  endtask

  task automatic add(input logic [7:0] b);
    frm_q.push_back(b);
  endtask

  task automatic build_t1(input logic [7:0] chk, input logic [7:0] tail);
    add(8'h52); add(8'h0E); add(8'h01);
    for (int i = 0; i < 8; i++) begin
      add(8'(i + 1));
      exp_pl[i] = 8'(i + 1);
    end
    add(chk); add(tail);
  endtask

  task automatic build_t2();
    add(8'h52); add(8'h07); add(8'h01); add(8'hAA); add(8'hFC); add(8'h9A);
    exp_pl[0] = 8'hAA;
  endtask

  task automatic send_seq();
    foreach (frm_q[i]) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = frm_q[i];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    frm_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    if (busy) check_val("idle_budget", busy, 0);
    idle(3);
  endtask

  task automatic expect_frame(input string tag, input int exp_n, input int exp_done,
                              input int exp_fmt, input int exp_chk, input int exp_ovf,
                              input int exp_tmo);
    check_val({tag, "_bytes"}, cap_n - b_cap, exp_n);
    for (int i = 0; i < exp_n; i++) begin
      if (b_cap + i < 256) begin
        check_val($sformatf("%s_data%0d", tag, i), cap_d[b_cap + i], exp_pl[i]);
        check_val($sformatf("%s_last%0d", tag, i), cap_l[b_cap + i], (i == exp_n - 1) ? 1 : 0);
      end
    end
    if (exp_n == 0) check_val({tag, "_no_valid"}, ovalid_n - b_ovalid, 0);
    check_val({tag, "_done"},    done_n - b_done, exp_done);
    check_val({tag, "_err_fmt"}, fmt_n - b_fmt, exp_fmt);
    check_val({tag, "_err_chk"}, chk_n - b_chk, exp_chk);
    check_val({tag, "_err_ovf"}, ovf_n - b_ovf, exp_ovf);
    check_val({tag, "_err_tmo"}, tmo_n - b_tmo, exp_tmo);
    check_val({tag, "_hold"},    hold_n - b_hold, 0);
    check_val({tag, "_cnt"},     frame_cnt, exp_cnt);
    $display("%s: bytes=%0d done=%0d fmt=%0d chk=%0d ovf=%0d tmo=%0d frame_cnt=%0d",
             tag, cap_n - b_cap, done_n - b_done, fmt_n - b_fmt, chk_n - b_chk,
             ovf_n - b_ovf, tmo_n - b_tmo, frame_cnt);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    idle(3);
    check_val("rst_busy",      busy, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_last",  out_last, 0);
    check_val("rst_out_data",  out_data, 0);
    check_val("rst_done",      done, 0);
    check_val("rst_errs",      {err_fmt, err_chk, err_ovf, err_timeout}, 0);
    check_val("rst_frame_cnt", frame_cnt, 0);
    $display("reset: busy=%0d out_valid=%0d frame_cnt=%0d", busy, out_valid, frame_cnt);
    rst = 1'b0;
    idle(2);
    exp_cnt = 0;

    snap(); build_t1(8'h7B, 8'h9A); send_seq(); wait_idle();
    exp_cnt++; expect_frame("t1_good8", 8, 1, 0, 0, 0, 0);

    snap(); build_t2(); send_seq(); wait_idle();
    exp_cnt++; expect_frame("t2_single", 1, 1, 0, 0, 0, 0);

    snap(); build_t1(8'h7C, 8'h9A); send_seq(); wait_idle();
    expect_frame("t3_bad_chk", 0, 0, 0, 1, 0, 0);

    snap(); build_t1(8'h7B, 8'h9B); send_seq(); wait_idle();
    expect_frame("t3_bad_tail", 0, 0, 1, 0, 0, 0);

    snap(); add(8'h52); add(8'h0F); build_t2(); send_seq(); wait_idle();
    exp_cnt++; expect_frame("t4_bad_len", 1, 1, 1, 0, 0, 0);

    snap(); add(8'h52); add(8'h0E); add(8'h02); build_t2(); send_seq(); wait_idle();
    exp_cnt++; expect_frame("t4_bad_cmd", 1, 1, 1, 0, 0, 0);

    // back-pressure 1010 plus one RX byte arriving mid-emission
    snap(); out_ready = 1'b0; build_t1(8'h7B, 8'h9A); send_seq();
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      out_ready = (k % 2 == 0);
      in_valid  = (k == 4);
      in_data   = 8'h33;
      if (!busy) break;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();
    exp_cnt++; expect_frame("t5_backpressure", 8, 1, 0, 0, 1, 0);

    snap(); add(8'h52); add(8'h0E); add(8'h01); add(8'h01); add(8'h02); send_seq();
    @(posedge clk); #1; en = 1'b0;
    @(posedge clk); #1; en = 1'b1;
    check_val("t6_en_busy", busy, 0);
    check_val("t6_en_out_valid", out_valid, 0);
    idle(3);
    expect_frame("t6_en_drop", 0, 0, 0, 0, 0, 0);

    snap(); build_t2(); send_seq(); wait_idle();
    exp_cnt++; expect_frame("t6_recover", 1, 1, 0, 0, 0, 0);

    snap(); add(8'h52); add(8'h0E); send_seq();
`ifdef FRAME_PARSER_TIMEOUT_EN
    idle(TMO + 20);
    check_val("t7_tmo_busy", busy, 0);
    expect_frame("t7_timeout", 0, 0, 0, 0, 0, 1);
`else
    idle(200);
    check_val("t7_stall_busy", busy, 1);
    @(posedge clk); #1; en = 1'b0;
    @(posedge clk); #1; en = 1'b1;
    idle(3);
    expect_frame("t7_stall", 0, 0, 0, 0, 0, 0);
`endif

    snap(); add(8'h52); add(8'h0E); add(8'h01); add(8'h01); add(8'h02); add(8'h03); send_seq();
    @(posedge clk); #1; rst = 1'b1;
    #2;
    check_val("t8_rst_busy", busy, 0);
    check_val("t8_rst_out_valid", out_valid, 0);
    check_val("t8_rst_frame_cnt", frame_cnt, 0);
    @(posedge clk); #1; rst = 1'b0;
    exp_cnt = 0;
    idle(3);
    expect_frame("t8_rst_mid", 0, 0, 0, 0, 0, 0);

    snap(); build_t1(8'h7B, 8'h9A); send_seq(); wait_idle();
    exp_cnt++; expect_frame("t9_after_rst", 8, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end

endmodule
